// File: rtl/ysyx_25020047_lsu_mc_if.sv
// LSU transaction bundle: EXU request, WBU response and the single-beat memory port.
// The LSU connects through 'slave'; whatever drives requests and models memory uses 'master'.
interface ysyx_25020047_lsu_mc_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_wen;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_wdata;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [AW-1:0]   mem_addr;
  logic            mem_wen;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wmask;
  logic            mem_rsp_valid;
  logic [DW-1:0]   mem_rdata;
  logic            mem_rsp_err;

  modport slave (
    input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready, mem_req_ready, mem_rsp_valid, mem_rdata, mem_rsp_err,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready, mem_req_ready, mem_rsp_valid, mem_rdata, mem_rsp_err,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_25020047_lsu_mc.sv
// Multi-cycle load/store unit: one outstanding access, byte-lane alignment of stores,
// extraction and sign/zero extension of loads, with misalignment reported as an error.
//
// state | meaning
// IDLE  | req_ready high, waiting for an EXU request
// MREQ  | memory request held on the bus until mem_req_ready
// MWAIT | waiting for mem_rsp_valid
// RESP  | response held until rsp_ready
module ysyx_25020047_lsu_mc #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  ysyx_25020047_lsu_mc_if.slave bus
);
  localparam int MW   = DW / 8;
  localparam int OFFW = $clog2(MW);

  typedef enum logic [1:0] {IDLE, MREQ, MWAIT, RESP} state_t;

  state_t          state;
  logic [OFFW-1:0] lat_off;
  logic [1:0]      lat_size;
  logic            lat_wen;
  logic            lat_unsigned;

  logic [OFFW-1:0] req_off;
  logic            illegal;
  logic [MW-1:0]   st_mask;
  logic [DW-1:0]   st_data;
  logic [AW-1:0]   aligned_addr;

  always_comb begin
    req_off = bus.req_addr[OFFW-1:0];
    case (bus.req_size)
      2'd0:    illegal = 1'b0;
      2'd1:    illegal = bus.req_addr[0];
      2'd2:    illegal = |bus.req_addr[1:0];
      default: illegal = (DW == 32) || (|bus.req_addr[2:0]);
    endcase
    st_mask = MW'((16'd1 << (5'd1 << bus.req_size)) - 16'd1) << req_off;
    st_data = bus.req_wdata << {req_off, 3'b000};
    // Upper bytes of req_wdata are don't-care; keep them off the bus.
    for (int i = 0; i < MW; i++) begin
      if (!st_mask[i]) st_data[8*i +: 8] = 8'h00;
    end
    aligned_addr = {bus.req_addr[AW-1:OFFW], OFFW'(0)};
  end

  logic [DW-1:0] ld_shift;
  logic [DW-1:0] ld_keep;
  logic          ld_sign;
  logic [DW-1:0] load_data;

  always_comb begin
    ld_shift = bus.mem_rdata >> {lat_off, 3'b000};
    ld_keep  = '1;
    ld_sign  = 1'b0;
    case (lat_size)
      2'd0: begin ld_keep = DW'(8'hFF);         ld_sign = ld_shift[7];  end
      2'd1: begin ld_keep = DW'(16'hFFFF);      ld_sign = ld_shift[15]; end
      2'd2: begin ld_keep = DW'(32'hFFFF_FFFF); ld_sign = ld_shift[31]; end
      default: ;
    endcase
    if (lat_unsigned) ld_sign = 1'b0;
    load_data = (ld_shift & ld_keep) | ({DW{ld_sign}} & ~ld_keep);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      lat_off           <= '0;
      lat_size          <= 2'd0;
      lat_wen           <= 1'b0;
      lat_unsigned      <= 1'b0;
      bus.req_ready     <= 1'b0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_rdata     <= '0;
      bus.rsp_err       <= 1'b0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_wen       <= 1'b0;
      bus.mem_wdata     <= '0;
      bus.mem_wmask     <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.req_ready <= 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready <= 1'b0;
            lat_off       <= req_off;
            lat_size      <= bus.req_size;
            lat_wen       <= bus.req_wen;
            lat_unsigned  <= bus.req_unsigned;
            if (illegal) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end else begin
              state             <= MREQ;
              bus.mem_req_valid <= 1'b1;
              bus.mem_addr      <= aligned_addr;
              bus.mem_wen       <= bus.req_wen;
              bus.mem_wdata     <= st_data;
              bus.mem_wmask     <= bus.req_wen ? st_mask : '0;
            end
          end
        end
        MREQ: begin
          if (bus.mem_req_ready) begin
            state             <= MWAIT;
            bus.mem_req_valid <= 1'b0;
            bus.mem_wen       <= 1'b0;
            bus.mem_wmask     <= '0;
          end
        end
        MWAIT: begin
          if (bus.mem_rsp_valid) begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= bus.mem_rsp_err;
            bus.rsp_rdata <= (lat_wen || bus.mem_rsp_err) ? '0 : load_data;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
